whack_game_core: RTL
====================

WHACK_GAME_CORE -- requirements
Module: whack_game_core

Interface
REQ-001 Parameter N_TARGETS, default 16: number of target LEDs; legal range 2..16.
REQ-002 Parameter TICK_DIV, default 100_000_000: clk cycles per game second; legal minimum 2.
REQ-003 Parameter GAME_SECS, default 30: round length in seconds; legal range 1..99.
REQ-004 Parameter WIN_SCORE, default 10: score that ends the round as a win; legal range 1..99.
REQ-005 Parameter MISS_PENALTY, default 0: when 1, a wrong hit decrements the score.
REQ-006 Parameter LFSR_SEED, default 16'hACE1: non-zero LFSR reset value.
REQ-007 Port clk  input  1: single system clock; all state changes on its rising edge.
REQ-008 Port rst  input  1: asynchronous, active-low reset.
REQ-009 Port start  input  1: debounced, single-cycle start pulse.
REQ-010 Port hit_valid  input  1: single-cycle pulse indicating a player hit.
REQ-011 Port hit_idx  input  4: target index of the hit.
REQ-012 Port led  output  N_TARGETS: one-hot active target during PLAY.
REQ-013 Port disp  output  16: four 4-bit display codes {d3,d2,d1,d0}; 0-9 digit, 10 W, 11 I, 12 N, 13 dash.
REQ-014 Port state  output  2: 0 IDLE, 1 PLAY, 2 DONE.
REQ-015 Port win  output  1: high in DONE when the round was won.

Function
REQ-016 The FSM SHALL transition IDLE->PLAY on start, PLAY->DONE on end condition, and DONE->PLAY on start; start in PLAY SHALL be ignored.
REQ-017 On the start pulse at cycle t, the block SHALL present state=PLAY, score=0, time_left=GAME_SECS, tick counter=0, and a one-hot led at t+1.
REQ-018 The tick counter SHALL count clk cycles in PLAY only, wrap at TICK_DIV-1, and assert a one-cycle tick on wrap; the first tick SHALL occur TICK_DIV cycles after PLAY entry.
REQ-019 On each tick, time_left SHALL decrement by 1 and a new target SHALL be drawn.
REQ-020 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle in all states.
REQ-021 The target index SHALL be lfsr[3:0] mod N_TARGETS; if that index equals the current target, the index SHALL be (index+1) mod N_TARGETS.
REQ-022 A correct hit (hit_valid with hit_idx equal to the current target) SHALL increment score by 1 and draw a new target, both visible the next cycle.
REQ-023 A wrong hit, including hit_idx >= N_TARGETS, SHALL leave the target unchanged, decrement score saturating at 0 when MISS_PENALTY=1, and leave score unchanged otherwise.
REQ-024 hit_valid SHALL be ignored outside PLAY.
REQ-025 If a hit and a tick occur in the same cycle, both SHALL take effect, with exactly one new target drawn.
REQ-026 The end condition SHALL be score reaching WIN_SCORE or time_left reaching 0; if both occur in the same cycle, the result SHALL be a win.
REQ-027 The block SHALL enter DONE the cycle after the end condition, with led=0 and win latched (1 if score>=WIN_SCORE, else 0).
REQ-028 In DONE, score and time_left SHALL hold.
REQ-029 disp in IDLE SHALL be {13,13,13,13}.
REQ-030 disp in PLAY SHALL be {time tens, time ones, score tens, score ones}.
REQ-031 disp in DONE SHALL be {13,10,11,12} when win=1, and {0,0,score tens, score ones} when win=0.
REQ-032 Score and time_left SHALL be 7-bit registers.
REQ-033 Binary-to-BCD conversion SHALL be combinational for values 0..99.
REQ-034 All outputs SHALL be registered or derived only from registered state.

Reset
REQ-035 rst low SHALL asynchronously force state=IDLE, led=0, win=0, score=0, time_left=GAME_SECS, tick counter=0, lfsr=LFSR_SEED, and disp={13,13,13,13}.
REQ-036 Reset asserted mid-round SHALL abandon the round; after release, the block SHALL wait in IDLE for start.
REQ-037 Reset SHALL take priority over every other event in the same cycle.

Verification (TICK_DIV=10, GAME_SECS=3, WIN_SCORE=2, N_TARGETS=8)
REQ-038 Reset then start -> next cycle state=1, disp={0,3,0,0}, led one-hot within bits 7:0; disp={0,2,0,0} after 10 cycles.
REQ-039 Two correct hits 3 cycles apart -> score 1 then 2; state=2, win=1, disp={13,10,11,12}, led=0 one cycle after the second hit.
REQ-040 No hits for 30 cycles -> state=2, win=0, disp={0,0,0,0}; start -> state=1, disp={0,3,0,0}.
REQ-041 MISS_PENALTY=1: wrong hit at score 0 -> score stays 0; correct hit then wrong hit -> score 1 then 0, target unchanged after the wrong hit.
REQ-042 Winning hit in the same cycle as the final tick -> win=1; hit_idx=9 -> treated as a miss; rst low mid-PLAY -> immediately state=0, led=0.

Source files
------------

// File: rtl/whack_game_core.sv
// Whack-a-mole game core: a round timer, a pseudo-random target, score
// keeping and a four-digit display encoder. The FSM state is visible on
// the state output. start and hit_valid are single-cycle pulses sampled on
// the rising clock edge; there is no backpressure, and every pulse seen in
// a state that accepts it takes effect on that same edge.
module whack_game_core #(
  parameter int          N_TARGETS    = 16,
  parameter int          TICK_DIV     = 100_000_000,
  parameter int          GAME_SECS    = 30,
  parameter int          WIN_SCORE    = 10,
  parameter int          MISS_PENALTY = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hit_valid,
  input  logic [3:0]           hit_idx,
  output logic [N_TARGETS-1:0] led,
  output logic [15:0]          disp,
  output logic [1:0]           state,
  output logic                 win
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                   CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]           SECS_INIT = 7'(GAME_SECS);
  localparam logic [6:0]           SCORE_WIN = 7'(WIN_SCORE);
  localparam logic [4:0]           N_T5      = 5'(N_TARGETS);
  localparam logic [3:0]           IDX_LAST  = 4'(N_TARGETS - 1);
  localparam logic [N_TARGETS-1:0] LED_ONE   = {{(N_TARGETS-1){1'b0}}, 1'b1};

  // Display glyph codes.
  localparam logic [3:0] G_W    = 4'd10;
  localparam logic [3:0] G_I    = 4'd11;
  localparam logic [3:0] G_N    = 4'd12;
  localparam logic [3:0] G_DASH = 4'd13;

  // Registered state.
  state_t           r_state;
  logic [6:0]       r_score;
  logic [6:0]       r_time;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_lfsr;
  logic [3:0]       r_tgt;
  logic             r_win;

  // Next-state values.
  state_t           w_state_nxt;
  logic [6:0]       w_score_nxt;
  logic [6:0]       w_time_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_tgt_nxt;
  logic             w_win_nxt;

  // Helper wires.
  logic             w_lfsr_fb;
  logic [4:0]       w_mod_a;
  logic [3:0]       w_raw_idx;
  logic [3:0]       w_alt_idx;
  logic [3:0]       w_draw_idx;
  logic             w_in_play;
  logic             w_tick;
  logic             w_hit_legal;
  logic             w_hit_ok;
  logic             w_hit_bad;
  logic [7:0]       w_time_bcd;
  logic [7:0]       w_score_bcd;

  // Double-dabble binary to two-digit BCD; valid for inputs 0..99.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [14:0] sh;
    sh = {8'd0, v};
    for (int i = 0; i < 7; i++) begin
      if (sh[10:7] >= 4'd5) sh[10:7] = sh[10:7] + 4'd3;
      if (sh[14:11] >= 4'd5) sh[14:11] = sh[14:11] + 4'd3;
      sh = sh << 1;
    end
    return sh[14:7];
  endfunction

  // Fibonacci LFSR feedback, taps 16,14,13,11.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Candidate target: low nibble of the LFSR folded into the target range.
  // When it collides with the active target it is bumped by one (wrapping),
  // so every draw during play visibly moves the lit LED.
  assign w_mod_a    = {1'b0, r_lfsr[3:0]};
  assign w_raw_idx  = 4'(w_mod_a % N_T5);
  assign w_alt_idx  = (w_raw_idx == IDX_LAST) ? 4'd0 : (w_raw_idx + 4'd1);
  assign w_draw_idx = (w_raw_idx == r_tgt) ? w_alt_idx : w_raw_idx;

  assign w_in_play   = (r_state == S_PLAY);
  assign w_tick      = w_in_play && (r_cnt == CNT_LAST);
  assign w_hit_legal = ({1'b0, hit_idx} < N_T5);
  assign w_hit_ok    = w_in_play && hit_valid && w_hit_legal && (hit_idx == r_tgt);
  assign w_hit_bad   = w_in_play && hit_valid && !w_hit_ok;

  // LFSR free-runs in every state so the first target depends on when start arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Game state register: FSM, score, time, tick counter, target and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_score <= 7'd0;
      r_time  <= SECS_INIT;
      r_cnt   <= '0;
      r_tgt   <= 4'd0;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_score <= w_score_nxt;
      r_time  <= w_time_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt   <= w_tgt_nxt;
      r_win   <= w_win_nxt;
    end
  end

  // Next-state logic: round start, scoring, second ticks and the end check.
  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_time_nxt  = r_time;
    w_cnt_nxt   = r_cnt;
    w_tgt_nxt   = r_tgt;
    w_win_nxt   = r_win;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_PLAY;
          w_score_nxt = 7'd0;
          w_time_nxt  = SECS_INIT;
          w_cnt_nxt   = '0;
          // No target is lit outside play, so there is nothing to avoid.
          w_tgt_nxt   = w_raw_idx;
          w_win_nxt   = 1'b0;
        end
      end
      S_PLAY: begin
        // Tick counter wraps at TICK_DIV-1; the wrap cycle is the tick.
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_time != 7'd0) w_time_nxt = r_time - 7'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_hit_ok) begin
          w_score_nxt = r_score + 7'd1;
        end else if (w_hit_bad && (MISS_PENALTY != 0) && (r_score != 7'd0)) begin
          w_score_nxt = r_score - 7'd1;
        end
        // A hit and a tick together still draw only one new target.
        if (w_hit_ok || w_tick) w_tgt_nxt = w_draw_idx;
        // Reaching the winning score takes precedence over time running out.
        if ((w_score_nxt >= SCORE_WIN) || (w_time_nxt == 7'd0)) begin
          w_state_nxt = S_DONE;
          w_win_nxt   = (w_score_nxt >= SCORE_WIN);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_time_bcd  = bin2bcd(r_time);
  assign w_score_bcd = bin2bcd(r_score);

  // Display encoder, derived only from registered state.
  always_comb begin
    disp = {G_DASH, G_DASH, G_DASH, G_DASH};
    case (r_state)
      S_PLAY: disp = {w_time_bcd, w_score_bcd};
      S_DONE: begin
        if (r_win) disp = {G_DASH, G_W, G_I, G_N};
        else       disp = {8'h00, w_score_bcd};
      end
      default: disp = {G_DASH, G_DASH, G_DASH, G_DASH};
    endcase
  end

  assign led   = w_in_play ? (LED_ONE << r_tgt) : '0;
  assign state = r_state;
  assign win   = r_win;

endmodule
